// File: rtl/mem_pkg.sv
// Shared definitions for the on-chip mem block and its read-side clients.
package mem_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADD_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/mem_out_reg.sv
// One-entry output register with valid/ready handshake and a last-word flag.
module mem_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;

  // A load always wins over a consume: the new word replaces the one just taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read client for mem: issues sequential reads and streams words out
// over valid/ready with a last flag and a done pulse.
module mem_burst_reader
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADD_WIDTH  = DEF_ADD_WIDTH,
  parameter int LEN_WIDTH  = DEF_ADD_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic [ADD_WIDTH-1:0]  req_addr_in,
  input  logic [LEN_WIDTH-1:0]  req_len_in,
  output logic                  mem_read_en_out,
  output logic [ADD_WIDTH-1:0]  mem_read_addr_out,
  input  logic [DATA_WIDTH-1:0] mem_read_data_in,
  output logic                  data_valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_last_out,
  input  logic                  data_ready_in,
  output logic                  busy_out,
  output logic                  done_out
);

  rd_state_t            r_state;
  rd_state_t            w_state_next;
  logic [ADD_WIDTH-1:0] r_addr_q;
  logic [LEN_WIDTH-1:0] r_rem_q;
  logic                 w_req_fire;
  logic                 w_rd_issue;
  logic                 w_rem_one;
  logic                 w_last_fire;

  assign w_req_fire  = req_valid_in && req_ready_out;
  assign w_rem_one   = (r_rem_q == LEN_WIDTH'(1));
  assign w_last_fire = data_valid_out && data_ready_in && data_last_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_req_fire) w_state_next = (req_len_in != '0) ? READ : DONE;
      READ:    if (w_rd_issue && w_rem_one) w_state_next = DRAIN;
      DRAIN:   if (w_last_fire) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // A read is issued only when the output register can take its word this edge.
  always_comb begin
    req_ready_out = 1'b0;
    busy_out      = 1'b1;
    done_out      = 1'b0;
    w_rd_issue    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_out = 1'b1;
        busy_out      = 1'b0;
      end
      READ:    w_rd_issue = !data_valid_out || data_ready_in;
      DONE:    done_out = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_q <= '0;
      r_rem_q  <= '0;
    end else if (w_req_fire) begin
      r_addr_q <= req_addr_in;
      r_rem_q  <= req_len_in;
    end else if (w_rd_issue) begin
      r_addr_q <= r_addr_q + 1'b1;
      r_rem_q  <= r_rem_q - 1'b1;
    end
  end

  assign mem_read_en_out   = w_rd_issue;
  assign mem_read_addr_out = r_addr_q;

  mem_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_rd_issue),
    .i_data  (mem_read_data_in),
    .i_last  (w_rem_one),
    .i_ready (data_ready_in),
    .o_valid (data_valid_out),
    .o_data  (data_out),
    .o_last  (data_last_out)
  );

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader against a combinational-read memory model.
module tb_mem_burst_reader;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int LW = 9;

  logic          clk;
  logic          rst;
  logic          req_valid_in;
  logic          req_ready_out;
  logic [AW-1:0] req_addr_in;
  logic [LW-1:0] req_len_in;
  logic          mem_read_en_out;
  logic [AW-1:0] mem_read_addr_out;
  logic [DW-1:0] mem_read_data_in;
  logic          data_valid_out;
  logic [DW-1:0] data_out;
  logic          data_last_out;
  logic          data_ready_in;
  logic          busy_out;
  logic          done_out;

  logic [DW-1:0] mem_model [0:255];
  int n_cmp;
  int n_err;

  assign mem_read_data_in = mem_model[mem_read_addr_out];

  mem_burst_reader #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_in      (req_valid_in),
    .req_ready_out     (req_ready_out),
    .req_addr_in       (req_addr_in),
    .req_len_in        (req_len_in),
    .mem_read_en_out   (mem_read_en_out),
    .mem_read_addr_out (mem_read_addr_out),
    .mem_read_data_in  (mem_read_data_in),
    .data_valid_out    (data_valid_out),
    .data_out          (data_out),
    .data_last_out     (data_last_out),
    .data_ready_in     (data_ready_in),
    .busy_out          (busy_out),
    .done_out          (done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (req_ready_out !== 1'b1) begin n_err++; $display("FAIL rst_req_ready got %b exp 1", req_ready_out); end
    n_cmp++; if (mem_read_en_out !== 1'b0) begin n_err++; $display("FAIL rst_read_en got %b exp 0", mem_read_en_out); end
    n_cmp++; if (mem_read_addr_out !== 8'h00) begin n_err++; $display("FAIL rst_read_addr got %h exp 00", mem_read_addr_out); end
    n_cmp++; if (data_valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", data_valid_out); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rst_data got %h exp 00", data_out); end
    n_cmp++; if (data_last_out !== 1'b0) begin n_err++; $display("FAIL rst_last got %b exp 0", data_last_out); end
    n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy_out); end
    n_cmp++; if (done_out !== 1'b0) begin n_err++; $display("FAIL rst_done got %b exp 0", done_out); end
    $display("reset: checked all outputs");
  endtask

  task automatic test_basic();
    logic [7:0] exp_d;
    req_addr_in = 8'h10; req_len_in = 9'd4; req_valid_in = 1'b1; data_ready_in = 1'b1;
    #1;
    n_cmp++; if (req_ready_out !== 1'b1) begin n_err++; $display("FAIL basic_req_ready got %b exp 1", req_ready_out); end
    tick();
    req_valid_in = 1'b0;
    n_cmp++; if (mem_read_en_out !== 1'b1) begin n_err++; $display("FAIL basic_first_en got %b exp 1", mem_read_en_out); end
    n_cmp++; if (mem_read_addr_out !== 8'h10) begin n_err++; $display("FAIL basic_first_addr got %h exp 10", mem_read_addr_out); end
    n_cmp++; if (data_valid_out !== 1'b0) begin n_err++; $display("FAIL basic_first_valid got %b exp 0", data_valid_out); end
    n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b exp 1", busy_out); end
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_d = 8'h11 + 8'(k);
      n_cmp++; if (data_valid_out !== 1'b1) begin n_err++; $display("FAIL basic_valid[%0d] got %b exp 1", k, data_valid_out); end
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL basic_data[%0d] got %h exp %h", k, data_out, exp_d); end
      n_cmp++; if (data_last_out !== (k == 3)) begin n_err++; $display("FAIL basic_last[%0d] got %b exp %b", k, data_last_out, (k == 3)); end
      n_cmp++; if (done_out !== 1'b0) begin n_err++; $display("FAIL basic_early_done[%0d] got %b exp 0", k, done_out); end
      $display("basic: word %0d data=%h last=%b", k, data_out, data_last_out);
      tick();
    end
    n_cmp++; if (done_out !== 1'b1) begin n_err++; $display("FAIL basic_done got %b exp 1", done_out); end
    n_cmp++; if (data_valid_out !== 1'b0) begin n_err++; $display("FAIL basic_valid_after got %b exp 0", data_valid_out); end
    tick();
    n_cmp++; if (done_out !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got %b exp 0", done_out); end
    n_cmp++; if (req_ready_out !== 1'b1) begin n_err++; $display("FAIL basic_idle_ready got %b exp 1", req_ready_out); end
  endtask

  task automatic test_wrap();
    int nrd, nwd;
    bit seen_done;
    logic [7:0] exp_a, exp_d;
    nrd = 0; nwd = 0; seen_done = 1'b0;
    req_addr_in = 8'hFE; req_len_in = 9'd4; req_valid_in = 1'b1; data_ready_in = 1'b1;
    tick();
    req_valid_in = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      if (mem_read_en_out) begin
        exp_a = 8'hFE + 8'(nrd);
        n_cmp++; if (mem_read_addr_out !== exp_a) begin n_err++; $display("FAIL wrap_addr[%0d] got %h exp %h", nrd, mem_read_addr_out, exp_a); end
        nrd++;
      end
      if (data_valid_out && data_ready_in) begin
        exp_d = 8'hFF + 8'(nwd);
        n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL wrap_data[%0d] got %h exp %h", nwd, data_out, exp_d); end
        n_cmp++; if (data_last_out !== (nwd == 3)) begin n_err++; $display("FAIL wrap_last[%0d] got %b exp %b", nwd, data_last_out, (nwd == 3)); end
        $display("wrap: word %0d data=%h", nwd, data_out);
        nwd++;
      end
      if (done_out) seen_done = 1'b1; else tick();
    end
    n_cmp++; if (seen_done !== 1'b1) begin n_err++; $display("FAIL wrap_done_timeout got %b exp 1", seen_done); end
    n_cmp++; if (nrd !== 4) begin n_err++; $display("FAIL wrap_reads got %0d exp 4", nrd); end
    n_cmp++; if (nwd !== 4) begin n_err++; $display("FAIL wrap_words got %0d exp 4", nwd); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [5:0] pat;
    int nwd, nstall;
    bit seen_done;
    logic [7:0] exp_d;
    pat = 6'b101001;
    nwd = 0; nstall = 0; seen_done = 1'b0;
    req_addr_in = 8'h20; req_len_in = 9'd6; req_valid_in = 1'b1; data_ready_in = 1'b1;
    tick();
    req_valid_in = 1'b0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      data_ready_in = pat[c % 6];
      #1;
      if (data_valid_out && !data_ready_in) begin
        nstall++;
        n_cmp++; if (mem_read_en_out !== 1'b0) begin n_err++; $display("FAIL bp_stall_en cycle %0d got %b exp 0", c, mem_read_en_out); end
      end
      if (data_valid_out && data_ready_in) begin
        exp_d = 8'h21 + 8'(nwd);
        n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL bp_data[%0d] got %h exp %h", nwd, data_out, exp_d); end
        n_cmp++; if (data_last_out !== (nwd == 5)) begin n_err++; $display("FAIL bp_last[%0d] got %b exp %b", nwd, data_last_out, (nwd == 5)); end
        $display("backpressure: word %0d data=%h", nwd, data_out);
        nwd++;
      end
      if (done_out) seen_done = 1'b1; else tick();
    end
    data_ready_in = 1'b1;
    n_cmp++; if (seen_done !== 1'b1) begin n_err++; $display("FAIL bp_done_timeout got %b exp 1", seen_done); end
    n_cmp++; if (nwd !== 6) begin n_err++; $display("FAIL bp_words got %0d exp 6", nwd); end
    n_cmp++; if (nstall == 0) begin n_err++; $display("FAIL bp_stalls got %0d exp >0", nstall); end
    tick();
  endtask

  task automatic test_zero();
    req_addr_in = 8'h33; req_len_in = 9'd0; req_valid_in = 1'b1; data_ready_in = 1'b1;
    tick();
    req_valid_in = 1'b0;
    n_cmp++; if (done_out !== 1'b1) begin n_err++; $display("FAIL zero_done got %b exp 1", done_out); end
    n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL zero_busy got %b exp 1", busy_out); end
    n_cmp++; if (mem_read_en_out !== 1'b0) begin n_err++; $display("FAIL zero_en got %b exp 0", mem_read_en_out); end
    n_cmp++; if (data_valid_out !== 1'b0) begin n_err++; $display("FAIL zero_valid got %b exp 0", data_valid_out); end
    tick();
    n_cmp++; if (done_out !== 1'b0) begin n_err++; $display("FAIL zero_done_pulse got %b exp 0", done_out); end
    n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL zero_busy_after got %b exp 0", busy_out); end
    n_cmp++; if (mem_read_en_out !== 1'b0) begin n_err++; $display("FAIL zero_en_after got %b exp 0", mem_read_en_out); end
    n_cmp++; if (req_ready_out !== 1'b1) begin n_err++; $display("FAIL zero_ready got %b exp 1", req_ready_out); end
    $display("zero: length-0 request completed");
  endtask

  task automatic test_reset_mid();
    int nwd;
    bit seen_done;
    logic [7:0] exp_d;
    req_addr_in = 8'h40; req_len_in = 9'd8; req_valid_in = 1'b1; data_ready_in = 1'b1;
    tick();
    req_valid_in = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      exp_d = 8'h41 + 8'(k);
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL rmid_data[%0d] got %h exp %h", k, data_out, exp_d); end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (req_ready_out !== 1'b1) begin n_err++; $display("FAIL rmid_req_ready got %b exp 1", req_ready_out); end
    n_cmp++; if (mem_read_en_out !== 1'b0) begin n_err++; $display("FAIL rmid_en got %b exp 0", mem_read_en_out); end
    n_cmp++; if (mem_read_addr_out !== 8'h00) begin n_err++; $display("FAIL rmid_addr got %h exp 00", mem_read_addr_out); end
    n_cmp++; if (data_valid_out !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b exp 0", data_valid_out); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rmid_data got %h exp 00", data_out); end
    n_cmp++; if (data_last_out !== 1'b0) begin n_err++; $display("FAIL rmid_last got %b exp 0", data_last_out); end
    n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b exp 0", busy_out); end
    n_cmp++; if (done_out !== 1'b0) begin n_err++; $display("FAIL rmid_done got %b exp 0", done_out); end
    $display("reset_mid: reset applied after 3 words");
    nwd = 0; seen_done = 1'b0;
    req_addr_in = 8'h00; req_len_in = 9'd2; req_valid_in = 1'b1;
    tick();
    req_valid_in = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      if (data_valid_out && data_ready_in) begin
        exp_d = 8'h01 + 8'(nwd);
        n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL rmid_post_data[%0d] got %h exp %h", nwd, data_out, exp_d); end
        $display("reset_mid: post word %0d data=%h", nwd, data_out);
        nwd++;
      end
      if (done_out) seen_done = 1'b1; else tick();
    end
    n_cmp++; if (seen_done !== 1'b1) begin n_err++; $display("FAIL rmid_done_timeout got %b exp 1", seen_done); end
    n_cmp++; if (nwd !== 2) begin n_err++; $display("FAIL rmid_post_words got %0d exp 2", nwd); end
    tick();
  endtask

  task automatic test_busy_req();
    int nwd;
    bit seen_done;
    logic [7:0] exp_d;
    nwd = 0; seen_done = 1'b0;
    req_addr_in = 8'h50; req_len_in = 9'd5; req_valid_in = 1'b1; data_ready_in = 1'b1;
    tick();
    req_addr_in = 8'h60; req_len_in = 9'd2;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      n_cmp++; if (req_ready_out !== 1'b0) begin n_err++; $display("FAIL busy_ready cycle %0d got %b exp 0", c, req_ready_out); end
      if (data_valid_out && data_ready_in) begin
        exp_d = 8'h51 + 8'(nwd);
        n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL busy_data[%0d] got %h exp %h", nwd, data_out, exp_d); end
        $display("busy: first burst word %0d data=%h", nwd, data_out);
        nwd++;
      end
      if (done_out) seen_done = 1'b1; else tick();
    end
    n_cmp++; if (seen_done !== 1'b1) begin n_err++; $display("FAIL busy_done_timeout got %b exp 1", seen_done); end
    n_cmp++; if (nwd !== 5) begin n_err++; $display("FAIL busy_words got %0d exp 5", nwd); end
    tick();
    n_cmp++; if (req_ready_out !== 1'b1) begin n_err++; $display("FAIL busy_idle_ready got %b exp 1", req_ready_out); end
    tick();
    req_valid_in = 1'b0;
    nwd = 0; seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      if (data_valid_out && data_ready_in) begin
        exp_d = 8'h61 + 8'(nwd);
        n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL busy_second_data[%0d] got %h exp %h", nwd, data_out, exp_d); end
        $display("busy: second burst word %0d data=%h", nwd, data_out);
        nwd++;
      end
      if (done_out) seen_done = 1'b1; else tick();
    end
    n_cmp++; if (seen_done !== 1'b1) begin n_err++; $display("FAIL busy_second_timeout got %b exp 1", seen_done); end
    n_cmp++; if (nwd !== 2) begin n_err++; $display("FAIL busy_second_words got %0d exp 2", nwd); end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'(i + 1);
    rst = 1'b1;
    req_valid_in = 1'b0;
    req_addr_in = '0;
    req_len_in = '0;
    data_ready_in = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero();
    test_reset_mid();
    test_busy_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
